jb_prach_oran_request_dispatch: RTL and testbench

JB_PRACH_ORAN_REQUEST_DISPATCH -- requirements
Module: jb_prach_oran_request_dispatch

---
 rtl/jb_prach_oran_request_dispatch_if.sv | 55 +++++
 rtl/jb_prach_oran_request_dispatch.sv | 178 +++++++++++++++++
 tb/tb_jb_prach_oran_request_dispatch.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jb_prach_oran_request_dispatch_if.sv
// ---------------------------------------------------------------------------
// jb_prach_oran_request_dispatch_if
//
// Bundles the two handshakes of the PRACH O-RAN request dispatcher:
//   - request FIFO side : fifo_empty, fifo_data[27:0] (head word), fifo_read
//   - section side      : sec_valid/sec_ready plus descriptor fields
//                         sec_frame[7:0], sec_subframe[3:0], sec_slot[5:0],
//                         sec_symbol[3:0], sec_port[5:0], sec_last
//
// Modports:
//   master - the dispatcher (pops the FIFO, drives descriptors)
//   slave  - the environment (FIFO owner and descriptor consumer)
// ---------------------------------------------------------------------------
interface jb_prach_oran_request_dispatch_if;
  logic        fifo_empty;
  logic [27:0] fifo_data;
  logic        fifo_read;

  logic        sec_valid;
  logic        sec_ready;
  logic [7:0]  sec_frame;
  logic [3:0]  sec_subframe;
  logic [5:0]  sec_slot;
  logic [3:0]  sec_symbol;
  logic [5:0]  sec_port;
  logic        sec_last;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  sec_ready,
    output fifo_read,
    output sec_valid,
    output sec_frame,
    output sec_subframe,
    output sec_slot,
    output sec_symbol,
    output sec_port,
    output sec_last
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output sec_ready,
    input  fifo_read,
    input  sec_valid,
    input  sec_frame,
    input  sec_subframe,
    input  sec_slot,
    input  sec_symbol,
    input  sec_port,
    input  sec_last
  );
endinterface

// File: rtl/jb_prach_oran_request_dispatch.sv
// ---------------------------------------------------------------------------
// jb_prach_oran_request_dispatch
//
// Pops PRACH requests from a request FIFO and expands each one into a run of
// per-symbol section descriptors (sec_symbol = start_symbol + k), clipped to
// the end of the slot.
//
// Parameters:
//   SYMS_PER_SLOT - symbols per slot; legal start symbols 0..SYMS_PER_SLOT-1
//
// Ports:
//   clk          - clock
//   rst          - synchronous, active-high reset
//   enable       - permits capture of new requests (never aborts one in flight)
//   num_rep[3:0] - descriptors per request, sampled at capture (0 acts as 1)
//   bus          - master modport: FIFO pop handshake and descriptor stream
//   busy         - high while descriptors of a request are being issued
//   sym_overflow - one-cycle pulse, cycle after a capture that was clipped
//                  to the slot end or dropped for an illegal start symbol
//   req_count    - (PRACH_ORAN_DISPATCH_STATS_EN only) FIFO pops, wraps
//   drop_count   - (PRACH_ORAN_DISPATCH_STATS_EN only) sym_overflow pulses
//
// Optional feature macro: PRACH_ORAN_DISPATCH_STATS_EN
//   Adds the req_count/drop_count statistics outputs.
// ---------------------------------------------------------------------------
module jb_prach_oran_request_dispatch #(
  parameter int unsigned SYMS_PER_SLOT = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [3:0]                        num_rep,
  jb_prach_oran_request_dispatch_if.master  bus,
  output logic                              busy,
  output logic                              sym_overflow
`ifdef PRACH_ORAN_DISPATCH_STATS_EN
  ,
  output logic [15:0]                       req_count,
  output logic [15:0]                       drop_count
`endif
);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched request fields and the current descriptor position
  logic [7:0] frame_q;
  logic [3:0] subframe_q;
  logic [5:0] slot_q;
  logic [3:0] symbol_q;
  logic [5:0] port_q;
  logic       last_q;
  logic [3:0] rem_q;      // descriptors still to follow the current one
  logic       ovf_q;

  // Capture-time decode of the FIFO head word
  logic [3:0] cap_start;
  logic [4:0] cap_rep;
  logic [4:0] cap_avail;
  logic [4:0] cap_cnt;
  logic       cap_bad;
  logic       cap_trunc;

  logic       capture;
  logic       handshake;

  assign cap_start = bus.fifo_data[9:6];

  always_comb begin
    cap_rep   = (num_rep == '0) ? 5'd1 : {1'b0, num_rep};
    cap_bad   = (32'(cap_start) >= SYMS_PER_SLOT);
    cap_avail = cap_bad ? '0 : 5'(SYMS_PER_SLOT - 32'(cap_start));
    cap_trunc = !cap_bad && (cap_rep > cap_avail);
    cap_cnt   = cap_trunc ? cap_avail : cap_rep;
  end

  // Next-state and strobes
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gates the pop so a reset cycle never consumes a FIFO entry
        if (!rst && enable && !bus.fifo_empty) begin
          capture = 1'b1;
          if (!cap_bad) begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.sec_ready) begin
          handshake = 1'b1;
          if (last_q) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Descriptor datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q    <= '0;
      subframe_q <= '0;
      slot_q     <= '0;
      symbol_q   <= '0;
      port_q     <= '0;
      last_q     <= 1'b0;
      rem_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= capture && (cap_bad || cap_trunc);
      if (capture && !cap_bad) begin
        frame_q    <= bus.fifo_data[27:20];
        subframe_q <= bus.fifo_data[19:16];
        slot_q     <= bus.fifo_data[15:10];
        symbol_q   <= cap_start;
        port_q     <= bus.fifo_data[5:0];
        rem_q      <= 4'(cap_cnt - 5'd1);
        last_q     <= (cap_cnt == 5'd1);
      end else if (handshake) begin
        if (last_q) begin
          last_q <= 1'b0;
        end else begin
          // last is decided one step ahead so it is a plain register output
          symbol_q <= symbol_q + 4'd1;
          rem_q    <= rem_q - 4'd1;
          last_q   <= (rem_q == 4'd1);
        end
      end
    end
  end

  assign bus.fifo_read    = capture;
  assign bus.sec_valid    = (state_q == ISSUE);
  assign bus.sec_frame    = frame_q;
  assign bus.sec_subframe = subframe_q;
  assign bus.sec_slot     = slot_q;
  assign bus.sec_symbol   = symbol_q;
  assign bus.sec_port     = port_q;
  assign bus.sec_last     = last_q;
  assign busy             = (state_q == ISSUE);
  assign sym_overflow     = ovf_q;

`ifdef PRACH_ORAN_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      req_count  <= '0;
      drop_count <= '0;
    end else begin
      if (capture) begin
        req_count <= req_count + 16'd1;
      end
      if (ovf_q) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jb_prach_oran_request_dispatch.sv
// ---------------------------------------------------------------------------
// Self-checking bench for jb_prach_oran_request_dispatch.
// A transaction-level reference model turns every captured request into a
// queue of expected descriptors; each cycle the DUT outputs are compared with
// the queue head, the predicted pop strobe and the predicted overflow pulse.
// Directed scenarios are followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_jb_prach_oran_request_dispatch;

  localparam int unsigned SYMS = 14;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] num_rep;
  logic       busy;
  logic       sym_overflow;
`ifdef PRACH_ORAN_DISPATCH_STATS_EN
  logic [15:0] req_count;
  logic [15:0] drop_count;
`endif

  jb_prach_oran_request_dispatch_if bus ();

  jb_prach_oran_request_dispatch #(
    .SYMS_PER_SLOT(SYMS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .num_rep      (num_rep),
    .bus          (bus),
    .busy         (busy),
    .sym_overflow (sym_overflow)
`ifdef PRACH_ORAN_DISPATCH_STATS_EN
    ,
    .req_count    (req_count),
    .drop_count   (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment FIFO and reference model state
  logic [27:0] fq[$];
  logic [28:0] mq[$];          // {frame, sf, slot, symbol, port, last}
  logic        ovf_exp;
  logic [15:0] req_m;
  logic [15:0] drop_m;
  logic        rst_applied;

  int checks;
  int errors;
  int rd_total;
  int hs_total;
  int ovf_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] mkw(input logic [7:0] fr, input logic [3:0] sf,
                                      input logic [5:0] sl, input logic [3:0] sy,
                                      input logic [5:0] pt);
    return {fr, sf, sl, sy, pt};
  endfunction

  // Expected behaviour of one accepted request
  function automatic void model_capture(input logic [27:0] w, input logic [3:0] nr);
    int unsigned start;
    int unsigned rep;
    int unsigned avail;
    int unsigned cnt;
    start = 32'(w[9:6]);
    rep   = (nr == 4'd0) ? 1 : 32'(nr);
    if (start >= SYMS) begin
      ovf_exp = 1'b1;
      return;
    end
    avail   = SYMS - start;
    cnt     = (rep < avail) ? rep : avail;
    ovf_exp = (rep > avail);
    for (int unsigned k = 0; k < cnt; k++) begin
      mq.push_back({w[27:20], w[19:16], w[15:10], 4'(start + k), w[5:0], (k == cnt - 1)});
    end
  endfunction

  // One clock cycle: drive FIFO view, check outputs, advance model
  task automatic step();
    logic exp_rd;
    logic rd_obs;
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : 28'h0;
    #1;
    exp_rd = !rst && enable && (fq.size() != 0) && (mq.size() == 0);
    rd_obs = bus.fifo_read;
    chk("fifo_read", 32'(rd_obs), 32'(exp_rd));
    chk("sec_valid", 32'(bus.sec_valid), 32'(mq.size() != 0));
    chk("busy", 32'(busy), 32'(mq.size() != 0));
    chk("sym_overflow", 32'(sym_overflow), 32'(ovf_exp));
    if (mq.size() != 0) begin
      chk("descriptor", 32'({bus.sec_frame, bus.sec_subframe, bus.sec_slot,
                             bus.sec_symbol, bus.sec_port, bus.sec_last}), 32'(mq[0]));
    end
    if (rst_applied) begin
      chk("reset_fields", 32'({bus.sec_frame, bus.sec_subframe, bus.sec_slot,
                               bus.sec_symbol, bus.sec_port, bus.sec_last}), 32'd0);
    end
`ifdef PRACH_ORAN_DISPATCH_STATS_EN
    chk("req_count", 32'(req_count), 32'(req_m));
    chk("drop_count", 32'(drop_count), 32'(drop_m));
`endif
    rd_total += int'(rd_obs);
    if (bus.sec_valid === 1'b1 && bus.sec_ready === 1'b1) hs_total++;
    if (sym_overflow === 1'b1) ovf_total++;
    @(posedge clk);
    rst_applied = rst;
    if (rst) begin
      mq.delete();
      ovf_exp = 1'b0;
      req_m   = '0;
      drop_m  = '0;
    end else begin
      if (ovf_exp) drop_m = drop_m + 16'd1;
      ovf_exp = 1'b0;
      if (mq.size() != 0 && bus.sec_ready) void'(mq.pop_front());
      if (exp_rd) begin
        req_m = req_m + 16'd1;
        model_capture(fq[0], num_rep);
      end
    end
    if (rd_obs && fq.size() != 0) void'(fq.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
  endtask

  initial begin
    int rd0;
    int hs0;
    int ov0;
    checks      = 0;
    errors      = 0;
    rd_total    = 0;
    hs_total    = 0;
    ovf_total   = 0;
    ovf_exp     = 1'b0;
    req_m       = '0;
    drop_m      = '0;
    rst         = 1'b1;
    enable      = 1'b0;
    num_rep     = 4'd0;
    bus.sec_ready  = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = 28'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_applied = 1'b1;
    do_reset();

    // Basic request: symbols 2..5, no stall
    rd0 = rd_total; hs0 = hs_total; ov0 = ovf_total;
    enable = 1'b1; num_rep = 4'd4; bus.sec_ready = 1'b1;
    fq.push_back(mkw(8'h12, 4'd3, 6'd5, 4'd2, 6'd7));
    run(8);
    chk("basic_reads", 32'(rd_total - rd0), 32'd1);
    chk("basic_handshakes", 32'(hs_total - hs0), 32'd4);
    chk("basic_overflow", 32'(ovf_total - ov0), 32'd0);

    // Same request with back-pressure
    rd0 = rd_total; hs0 = hs_total;
    fq.push_back(mkw(8'h12, 4'd3, 6'd5, 4'd2, 6'd7));
    for (int i = 0; i < 16; i++) begin
      bus.sec_ready = (i % 3 == 0);
      step();
    end
    chk("stall_reads", 32'(rd_total - rd0), 32'd1);
    chk("stall_handshakes", 32'(hs_total - hs0), 32'd4);

    // Truncated at slot end
    rd0 = rd_total; hs0 = hs_total; ov0 = ovf_total;
    bus.sec_ready = 1'b1; num_rep = 4'd5;
    fq.push_back(mkw(8'hA5, 4'd9, 6'd33, 4'd12, 6'd63));
    run(6);
    chk("trunc_handshakes", 32'(hs_total - hs0), 32'd2);
    chk("trunc_overflow", 32'(ovf_total - ov0), 32'd1);

    // Illegal start symbol: popped and dropped
    rd0 = rd_total; hs0 = hs_total; ov0 = ovf_total;
    num_rep = 4'd3;
    fq.push_back(mkw(8'h01, 4'd1, 6'd1, 4'd14, 6'd1));
    run(4);
    chk("drop_reads", 32'(rd_total - rd0), 32'd1);
    chk("drop_handshakes", 32'(hs_total - hs0), 32'd0);
    chk("drop_overflow", 32'(ovf_total - ov0), 32'd1);

    // num_rep = 0 behaves as 1, and is changed mid-request elsewhere
    num_rep = 4'd0;
    fq.push_back(mkw(8'h33, 4'd0, 6'd0, 4'd13, 6'd2));
    run(4);

    // Three back-to-back requests
    rd0 = rd_total; hs0 = hs_total;
    num_rep = 4'd2;
    for (int i = 0; i < 3; i++) fq.push_back(mkw(8'(i + 1), 4'(i), 6'(i), 4'(i), 6'(i)));
    run(14);
    chk("b2b_reads", 32'(rd_total - rd0), 32'd3);
    chk("b2b_handshakes", 32'(hs_total - hs0), 32'd6);
    do_reset();

    // Reset during the second descriptor, next request queued behind it
    rd0 = rd_total;
    num_rep = 4'd4;
    fq.push_back(mkw(8'h44, 4'd4, 6'd4, 4'd2, 6'd4));
    fq.push_back(mkw(8'h55, 4'd5, 6'd5, 4'd6, 6'd5));
    run(2);                 // capture, first descriptor
    rst = 1'b1;             // second descriptor is on the bus now
    run(3);
    rst = 1'b0;
    chk("rst_reads", 32'(rd_total - rd0), 32'd1);
    rd0 = rd_total; hs0 = hs_total;
    run(7);
    chk("after_rst_reads", 32'(rd_total - rd0), 32'd1);
    chk("after_rst_handshakes", 32'(hs_total - hs0), 32'd4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0) num_rep = 4'($urandom_range(0, 15));
      bus.sec_ready = ($urandom_range(0, 2) != 0);
      if (fq.size() < 3 && $urandom_range(0, 3) == 0) begin
        fq.push_back(mkw(8'($urandom), 4'($urandom), 6'($urandom),
                         4'($urandom_range(0, 15)), 6'($urandom)));
      end
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
